cache_miss_ctrl: RTL and testbench

Blocking single-outstanding cache controller between a requester (fetch or load unit) and one cache array instance. It looks up the block via the array's read port. On a miss it fetches the full block from the next memory level over a valid/ready channel, then writes it into the array through the byte-enabled write port. It returns the block to the requester and keeps saturating hit/miss statistics.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_sat_counter.sv | 30 +++
 rtl/cache_miss_ctrl.sv | 128 ++++++++++++
 tb/tb_cache_miss_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the blocking cache miss controller.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StMemWait,
        StFill,
        StResp
    } cache_ctrl_state_e;

    typedef logic [31:0] cnt_t;

    localparam cnt_t CntMax = 32'hFFFF_FFFF;

    function automatic int unsigned offset_bits(input int unsigned block_size);
        return $clog2(block_size / 8);
    endfunction

endpackage

// File: rtl/cache_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module cache_sat_counter
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    output cnt_t count_o
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Blocking single-outstanding cache controller: lookup, refill on miss, array fill, respond.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = 128
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BLOCK_SIZE-1:0]   rsp_data,
    output logic                    rsp_hit,

    output logic [ADDR_WIDTH-1:0]   crd_addr,
    input  logic [BLOCK_SIZE-1:0]   crd_data,
    input  logic                    crd_hit,

    output logic [ADDR_WIDTH-1:0]   cwr_addr,
    output logic [BLOCK_SIZE-1:0]   cwr_data,
    output logic [BLOCK_SIZE/8-1:0] cwr_we,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,

    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [BLOCK_SIZE-1:0]   mem_rsp_data,

    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int unsigned OffsetBits = offset_bits(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((1 << OffsetBits) - 1);

    cache_ctrl_state_e      state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_SIZE-1:0]  buf_q;
    logic                   hit_q;

    logic inc_hit, inc_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            buf_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr & ~OffMask;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    hit_q <= crd_hit;
                    if (crd_hit) begin
                        buf_q   <= crd_data;
                        state_q <= StResp;
                    end else begin
                        state_q <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (mem_req_ready) begin
                        state_q <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (mem_rsp_valid) begin
                        buf_q   <= mem_rsp_data;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Counters increment on the same edge that leaves LOOKUP.
    assign inc_hit  = (state_q == StLookup) && crd_hit;
    assign inc_miss = (state_q == StLookup) && !crd_hit;

    cache_sat_counter u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_hit),
        .count_o (hit_count)
    );

    cache_sat_counter u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inc_miss),
        .count_o (miss_count)
    );

    // req_ready must also read 0 while reset is held, before any edge arrives.
    assign req_ready     = (state_q == StIdle) && !rst;
    assign rsp_valid     = (state_q == StResp);
    assign rsp_data      = buf_q;
    assign rsp_hit       = hit_q;
    assign crd_addr      = addr_q;
    assign cwr_addr      = addr_q;
    assign cwr_data      = buf_q;
    assign cwr_we        = (state_q == StFill) ? '1 : '0;
    assign mem_req_valid = (state_q == StMemReq);
    assign mem_req_addr  = addr_q;
    assign mem_rsp_ready = (state_q == StMemWait);

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with hand-computed expected values.
module tb_cache_miss_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned BS = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AW-1:0]   req_addr = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [BS-1:0]   rsp_data;
    logic            rsp_hit;
    logic [AW-1:0]   crd_addr;
    logic [BS-1:0]   crd_data = '0;
    logic            crd_hit = 1'b0;
    logic [AW-1:0]   cwr_addr;
    logic [BS-1:0]   cwr_data;
    logic [BS/8-1:0] cwr_we;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_rsp_valid = 1'b0;
    logic            mem_rsp_ready;
    logic [BS-1:0]   mem_rsp_data = '0;
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;

    int total = 0;
    int bad = 0;
    int we_cycles = 0;
    int mreq_cycles = 0;

    localparam logic [BS-1:0] DHit  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [BS-1:0] DFill = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [BS-1:0] DBp   = 128'hA5A5_0001_0002_0003_0004_0005_0006_5A5A;
    localparam logic [BS-1:0] DHit2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [BS-1:0] DJunk = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [BS-1:0] DNew  = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;

    always #5 clk = ~clk;

    // Cycle counts sampled on the active edge, before state updates.
    always @(posedge clk) begin
        if (cwr_we != '0) we_cycles++;
        if (mem_req_valid) mreq_cycles++;
    end

    cache_miss_ctrl #(
        .ADDR_WIDTH (AW),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_hit       (rsp_hit),
        .crd_addr      (crd_addr),
        .crd_data      (crd_data),
        .crd_hit       (crd_hit),
        .cwr_addr      (cwr_addr),
        .cwr_data      (cwr_data),
        .cwr_we        (cwr_we),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    task automatic chk(input string tag, input logic [BS-1:0] got, input logic [BS-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Full hit transaction: accept, LOOKUP, RESP two cycles after acceptance.
    task automatic do_hit(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                          input logic [BS-1:0] data, input logic [31:0] exp_hits);
        int we0, mr0;
        we0 = we_cycles;
        mr0 = mreq_cycles;
        req_valid = 1'b1;
        req_addr  = addr;
        crd_hit   = 1'b1;
        crd_data  = data;
        tick();
        req_valid = 1'b0;
        chk("hit_lookup_ready", BS'(req_ready), BS'(0));
        chk("hit_lookup_rspv", BS'(rsp_valid), BS'(0));
        chk("hit_crd_addr", BS'(crd_addr), BS'(exp_addr));
        tick();
        chk("hit_rspv", BS'(rsp_valid), BS'(1));
        chk("hit_rsp_data", rsp_data, data);
        chk("hit_rsp_hit", BS'(rsp_hit), BS'(1));
        chk("hit_count", BS'(hit_count), BS'(exp_hits));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        crd_hit   = 1'b0;
        chk("hit_done_rspv", BS'(rsp_valid), BS'(0));
        chk("hit_done_ready", BS'(req_ready), BS'(1));
        chk("hit_no_we", BS'(we_cycles - we0), BS'(0));
        chk("hit_no_memreq", BS'(mreq_cycles - mr0), BS'(0));
    endtask

    // Miss with immediate mem_req_ready; refill arrives `delay` cycles after the handshake.
    task automatic do_miss(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                           input logic [BS-1:0] data, input int delay,
                           input logic [31:0] exp_miss);
        int we0;
        we0 = we_cycles;
        req_valid     = 1'b1;
        req_addr      = addr;
        crd_hit       = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("miss_mreq_valid", BS'(mem_req_valid), BS'(1));
        chk("miss_mreq_addr", BS'(mem_req_addr), BS'(exp_addr));
        chk("miss_count", BS'(miss_count), BS'(exp_miss));
        tick();
        mem_req_ready = 1'b0;
        chk("miss_wait_mreqv", BS'(mem_req_valid), BS'(0));
        chk("miss_wait_ready", BS'(mem_rsp_ready), BS'(1));
        for (int i = 1; i < delay; i++) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        chk("fill_we", BS'(cwr_we), BS'(16'hFFFF));
        chk("fill_addr", BS'(cwr_addr), BS'(exp_addr));
        chk("fill_data", cwr_data, data);
        chk("fill_rspv", BS'(rsp_valid), BS'(0));
        tick();
        chk("miss_rspv", BS'(rsp_valid), BS'(1));
        chk("miss_rsp_data", rsp_data, data);
        chk("miss_rsp_hit", BS'(rsp_hit), BS'(0));
        chk("miss_one_fill", BS'(we_cycles - we0), BS'(1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("miss_done_ready", BS'(req_ready), BS'(1));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", BS'(req_ready), BS'(0));
        chk("rst_rsp_valid", BS'(rsp_valid), BS'(0));
        chk("rst_mreq_valid", BS'(mem_req_valid), BS'(0));
        chk("rst_mrsp_ready", BS'(mem_rsp_ready), BS'(0));
        chk("rst_cwr_we", BS'(cwr_we), BS'(0));
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_crd_addr", BS'(crd_addr), BS'(0));
        chk("rst_hit_count", BS'(hit_count), BS'(0));
        chk("rst_miss_count", BS'(miss_count), BS'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", BS'(req_ready), BS'(1));

        // Plain hit
        do_hit(32'h1004, 32'h1000, DHit, 32'd1);

        // Miss, refill 5 cycles after the request handshake
        do_miss(32'h200C, 32'h2000, DFill, 5, 32'd1);

        // Back-pressure on mem_req and on rsp
        req_valid = 1'b1;
        req_addr  = 32'h3047;
        crd_hit   = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_mreq_valid", BS'(mem_req_valid), BS'(1));
            chk("bp_mreq_addr", BS'(mem_req_addr), BS'(32'h3040));
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = DBp;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h9000;
        for (int i = 0; i < 7; i++) begin
            chk("bp_rsp_valid", BS'(rsp_valid), BS'(1));
            chk("bp_rsp_data", rsp_data, DBp);
            chk("bp_req_ready", BS'(req_ready), BS'(0));
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_done_rspv", BS'(rsp_valid), BS'(0));
        chk("bp_miss_count", BS'(miss_count), BS'(2));

        // Stray refill data during IDLE/LOOKUP must be ignored
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = DJunk;
        tick();
        chk("stray_idle_mrsp_ready", BS'(mem_rsp_ready), BS'(0));
        chk("stray_idle_req_ready", BS'(req_ready), BS'(1));
        do_hit(32'h1000, 32'h1000, DHit2, 32'd2);
        mem_rsp_valid = 1'b0;

        // Reset asserted in MEM_WAIT
        req_valid     = 1'b1;
        req_addr      = 32'h4000;
        crd_hit       = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        mem_req_ready = 1'b0;
        chk("mw_before_rst", BS'(mem_rsp_ready), BS'(1));
        #2 rst = 1'b1;
        #1;
        chk("mw_rst_mrsp_ready", BS'(mem_rsp_ready), BS'(0));
        chk("mw_rst_req_ready", BS'(req_ready), BS'(0));
        chk("mw_rst_mreq_addr", BS'(mem_req_addr), BS'(0));
        chk("mw_rst_rsp_data", rsp_data, '0);
        chk("mw_rst_hits", BS'(hit_count), BS'(0));
        chk("mw_rst_misses", BS'(miss_count), BS'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("mw_release_ready", BS'(req_ready), BS'(1));
        do_miss(32'h5008, 32'h5000, DNew, 2, 32'd1);

        // Saturation: preload hit counter just below the ceiling
        force dut.u_hit_cnt.cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.u_hit_cnt.cnt_q;
        tick();
        chk("sat_preload", BS'(hit_count), BS'(32'hFFFF_FFFE));
        do_hit(32'h6010, 32'h6010, DHit, 32'hFFFF_FFFF);
        do_hit(32'h6020, 32'h6020, DHit2, 32'hFFFF_FFFF);
        do_hit(32'h6030, 32'h6030, DHit, 32'hFFFF_FFFF);
        chk("sat_miss_unchanged", BS'(miss_count), BS'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
